// File: rtl/page_chain_recycler_if.sv
// Release-request, link-RAM and free-FIFO push signals of page_chain_recycler.
// slave is the recycler side; master is the surrounding dequeue/RAM/FIFO side.
interface page_chain_recycler_if #(
   parameter int ADDR_W = 11,
   parameter int LEN_W  = 7
);
   logic              rel_valid;
   logic              rel_ready;
   logic [ADDR_W-1:0] rel_head;
   logic [LEN_W-1:0]  rel_len;
   logic              link_rd_en;
   logic [ADDR_W-1:0] link_rd_addr;
   logic [ADDR_W-1:0] link_rd_data;
   logic              push_tail;
   logic [ADDR_W-1:0] tail_addr;

   modport master (
      output rel_valid, rel_head, rel_len, link_rd_data,
      input  rel_ready, link_rd_en, link_rd_addr, push_tail, tail_addr
   );

   modport slave (
      input  rel_valid, rel_head, rel_len, link_rd_data,
      output rel_ready, link_rd_en, link_rd_addr, push_tail, tail_addr
   );
endinterface

// File: rtl/page_chain_recycler.sv
// Queues released page chains and walks each through the link RAM, pushing one page
// per cycle into the free-page FIFO. Define PAGE_RECYCLE_CNT_EN for the free-list counter.
module page_chain_recycler #(
   parameter int ADDR_W = 11,
   parameter int LEN_W  = 7,
   parameter int QDEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   page_chain_recycler_if.slave bus,
`ifdef PAGE_RECYCLE_CNT_EN
   input  logic                 page_pop_i,
   output logic [ADDR_W:0]      free_cnt_o,
`endif
   output logic                 busy_o,
   output logic                 err_zero_len_o
);
   localparam int PW = $clog2(QDEPTH);
   localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

   typedef enum logic {IDLE, WALK} state_e;

   logic [ADDR_W-1:0] head_mem [QDEPTH];
   logic [LEN_W-1:0]  len_mem  [QDEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;

   state_e            state_q;
   logic              first_q;
   logic [ADDR_W-1:0] head_q;
   logic [LEN_W-1:0]  rem_q;

   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              accept, store, walking, last_page, pop;
   logic [ADDR_W-1:0] cur;

   // Zero-length requests are consumed without occupying a queue slot.
   always_comb begin
      accept    = bus.rel_valid && bus.rel_ready;
      store     = accept && (bus.rel_len != '0);
      walking   = (state_q == WALK);
      last_page = walking && (rem_q == LEN_W'(1));
      pop       = (count_q != '0) && (!walking || last_page);
      wr_ptr_d  = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d   = count_q;
      if (store && !pop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (!store && pop) begin
         count_d = count_q - (PW+1)'(1);
      end
      busy_d    = (count_d != '0) || pop || (walking && !last_page);
      err_d     = accept && (bus.rel_len == '0);
   end

   // The first page comes from the queue entry; later pages from last cycle's link read.
   assign cur              = first_q ? head_q : bus.link_rd_data;
   assign bus.rel_ready    = (count_q != QFULL);
   assign bus.push_tail    = walking;
   assign bus.tail_addr    = walking ? cur : '0;
   assign bus.link_rd_en   = walking && !last_page;
   assign bus.link_rd_addr = (walking && !last_page) ? cur : '0;
   assign busy_o           = busy_q;
   assign err_zero_len_o   = err_q;

   always_ff @(posedge clk) begin
      if (store) begin
         head_mem[wr_ptr_q] <= bus.rel_head;
         len_mem[wr_ptr_q]  <= bus.rel_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   // Reloading on the last page keeps back-to-back chains gapless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         first_q <= 1'b0;
         head_q  <= '0;
         rem_q   <= '0;
      end else if (pop) begin
         state_q <= WALK;
         first_q <= 1'b1;
         head_q  <= head_mem[rd_ptr_q];
         rem_q   <= len_mem[rd_ptr_q];
      end else if (walking) begin
         first_q <= 1'b0;
         rem_q   <= rem_q - LEN_W'(1);
         if (last_page) begin
            state_q <= IDLE;
         end
      end
   end

`ifdef PAGE_RECYCLE_CNT_EN
   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] free_cnt_q, free_cnt_d;

   // A push and a pop in the same cycle cancel; both ends saturate.
   always_comb begin
      free_cnt_d = free_cnt_q;
      if (walking && !page_pop_i && (free_cnt_q != CNT_MAX)) begin
         free_cnt_d = free_cnt_q + (ADDR_W+1)'(1);
      end else if (page_pop_i && !walking && (free_cnt_q != '0)) begin
         free_cnt_d = free_cnt_q - (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_cnt_q <= CNT_MAX;
      end else begin
         free_cnt_q <= free_cnt_d;
      end
   end

   assign free_cnt_o = free_cnt_q;
`endif
endmodule

// File: tb/tb_page_chain_recycler.sv
// Bench for page_chain_recycler: directed vector table, corner sequences and random
// traffic checked against a cycle-timeline model. Counter checks need PAGE_RECYCLE_CNT_EN.
module tb_page_chain_recycler;
   localparam int ADDR_W = 11;
   localparam int LEN_W  = 7;
   localparam int QDEPTH = 4;
   localparam int NPAGES = 2048;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic errZeroLen;
`ifdef PAGE_RECYCLE_CNT_EN
   logic            pagePop;
   logic [ADDR_W:0] freeCnt;
`endif

   page_chain_recycler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   page_chain_recycler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .QDEPTH(QDEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
`ifdef PAGE_RECYCLE_CNT_EN
      .page_pop_i     (pagePop),
      .free_cnt_o     (freeCnt),
`endif
      .busy_o         (busy),
      .err_zero_len_o (errZeroLen)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Link RAM: one-cycle read latency.
   logic [ADDR_W-1:0] linkMem [NPAGES];
   always @(posedge clk) begin
      if (bus.link_rd_en) bus.link_rd_data <= linkMem[bus.link_rd_addr];
   end

   typedef struct {
      bit                v;
      logic [ADDR_W-1:0] h;
      logic [LEN_W-1:0]  l;
      bit                ePush;
      logic [ADDR_W-1:0] eTail;
      bit                eRd;
      logic [ADDR_W-1:0] eRdAddr;
      bit                eBusy;
      bit                eReady;
      bit                eErr;
   } vec_t;
   vec_t tbl[$];

   int compared = 0;
   int mismatched = 0;

   // Timeline model: expected push / link-read address per absolute cycle.
   int pushAt[int];
   int readAt[int];
   int pendStart[$];
   int lastEnd, busyEnd, zeroAt, expFree;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("[TB] FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, want);
      end
   endtask

   task automatic addRow(input bit v, input int h, input int l, input bit p, input int t,
                         input bit r, input int ra, input bit b, input bit rdy, input bit e);
      vec_t x;
      x.v = v; x.h = ADDR_W'(h); x.l = LEN_W'(l);
      x.ePush = p; x.eTail = ADDR_W'(t); x.eRd = r; x.eRdAddr = ADDR_W'(ra);
      x.eBusy = b; x.eReady = rdy; x.eErr = e;
      tbl.push_back(x);
   endtask

   task automatic modelReset();
      pushAt.delete();
      readAt.delete();
      pendStart.delete();
      lastEnd = -1;
      busyEnd = -1;
      zeroAt  = -10;
      expFree = NPAGES;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " rel_ready"}, 32'(bus.rel_ready), 32'd1);
      checkOutput({tag, " push_tail"}, 32'(bus.push_tail), 32'd0);
      checkOutput({tag, " tail_addr"}, 32'(bus.tail_addr), 32'd0);
      checkOutput({tag, " link_rd_en"}, 32'(bus.link_rd_en), 32'd0);
      checkOutput({tag, " link_rd_addr"}, 32'(bus.link_rd_addr), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " err_zero_len"}, 32'(errZeroLen), 32'd0);
`ifdef PAGE_RECYCLE_CNT_EN
      checkOutput({tag, " free_cnt"}, 32'(freeCnt), 32'd2048);
`endif
   endtask

   // Compare this cycle against the model, then fold in any accepted request.
   task automatic checkModel();
      int c;
      int st;
      int len;
      bit eReady;
      bit ePush;
      logic [ADDR_W-1:0] p;
      c = cyc;
      while (pendStart.size() > 0 && pendStart[0] <= c) void'(pendStart.pop_front());
      eReady = (pendStart.size() < QDEPTH);
      ePush  = (pushAt.exists(c) != 0);
      checkOutput("rel_ready", 32'(bus.rel_ready), 32'(eReady));
      checkOutput("push_tail", 32'(bus.push_tail), 32'(ePush));
      checkOutput("tail_addr", 32'(bus.tail_addr), ePush ? pushAt[c] : 0);
      checkOutput("link_rd_en", 32'(bus.link_rd_en), 32'(readAt.exists(c) != 0));
      checkOutput("link_rd_addr", 32'(bus.link_rd_addr), readAt.exists(c) ? readAt[c] : 0);
      checkOutput("busy", 32'(busy), 32'(c <= busyEnd));
      checkOutput("err_zero_len", 32'(errZeroLen), 32'(c == zeroAt + 1));
`ifdef PAGE_RECYCLE_CNT_EN
      checkOutput("free_cnt", 32'(freeCnt), expFree);
      if (ePush && !pagePop && expFree < NPAGES) expFree++;
      else if (pagePop && !ePush && expFree > 0) expFree--;
`endif
      if (bus.rel_valid && eReady) begin
         len = int'(bus.rel_len);
         if (len == 0) begin
            zeroAt = c;
         end else begin
            st = (c + 2 > lastEnd + 1) ? c + 2 : lastEnd + 1;
            p  = bus.rel_head;
            for (int i = 0; i < len; i++) begin
               pushAt[st + i] = int'(p);
               if (i < len - 1) readAt[st + i] = int'(p);
               p = linkMem[p];
            end
            lastEnd = st + len - 1;
            busyEnd = lastEnd;
            pendStart.push_back(st);
         end
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [ADDR_W-1:0] h, input logic [LEN_W-1:0] l);
      bus.rel_valid = v;
      bus.rel_head  = h;
      bus.rel_len   = l;
      @(negedge clk);
      checkModel();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 3000 && cyc <= busyEnd + 1; k++) applyStimulus(1'b0, '0, '0);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      bus.rel_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      rst_n = 1'b0;
      bus.rel_valid = 1'b0;
      bus.rel_head  = '0;
      bus.rel_len   = '0;
`ifdef PAGE_RECYCLE_CNT_EN
      pagePop = 1'b0;
`endif
      for (int i = 0; i < NPAGES; i++) linkMem[ADDR_W'(i)] = '0;
      linkMem[5]  = 11'd9;
      linkMem[9]  = 11'd2;
      linkMem[10] = 11'd33;
      modelReset();

      repeat (2) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      //     v  head len | push tail rd rdaddr busy ready err
      addRow(1,  5, 3,   0,  0, 0,  0, 0, 1, 0);
      addRow(0,  0, 0,   0,  0, 0,  0, 1, 1, 0);
      addRow(0,  0, 0,   1,  5, 1,  5, 1, 1, 0);
      addRow(0,  0, 0,   1,  9, 1,  9, 1, 1, 0);
      addRow(0,  0, 0,   1,  2, 0,  0, 1, 1, 0);
      addRow(0,  0, 0,   0,  0, 0,  0, 0, 1, 0);
      addRow(1, 10, 2,   0,  0, 0,  0, 0, 1, 0);
      addRow(1, 20, 1,   0,  0, 0,  0, 1, 1, 0);
      addRow(0,  0, 0,   1, 10, 1, 10, 1, 1, 0);
      addRow(0,  0, 0,   1, 33, 0,  0, 1, 1, 0);
      addRow(0,  0, 0,   1, 20, 0,  0, 1, 1, 0);
      addRow(0,  0, 0,   0,  0, 0,  0, 0, 1, 0);
      addRow(1,  7, 0,   0,  0, 0,  0, 0, 1, 0);
      addRow(0,  0, 0,   0,  0, 0,  0, 0, 1, 1);
      addRow(0,  0, 0,   0,  0, 0,  0, 0, 1, 0);
      foreach (tbl[i]) begin
         bus.rel_valid = tbl[i].v;
         bus.rel_head  = tbl[i].h;
         bus.rel_len   = tbl[i].l;
         @(negedge clk);
         checkOutput($sformatf("tbl%0d push_tail", i), 32'(bus.push_tail), 32'(tbl[i].ePush));
         checkOutput($sformatf("tbl%0d tail_addr", i), 32'(bus.tail_addr), 32'(tbl[i].eTail));
         checkOutput($sformatf("tbl%0d link_rd_en", i), 32'(bus.link_rd_en), 32'(tbl[i].eRd));
         checkOutput($sformatf("tbl%0d link_rd_addr", i), 32'(bus.link_rd_addr), 32'(tbl[i].eRdAddr));
         checkOutput($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].eBusy));
         checkOutput($sformatf("tbl%0d rel_ready", i), 32'(bus.rel_ready), 32'(tbl[i].eReady));
         checkOutput($sformatf("tbl%0d err_zero_len", i), 32'(errZeroLen), 32'(tbl[i].eErr));
         @(posedge clk);
         #1;
      end

      resetDut();
      for (int i = 0; i < NPAGES; i++) linkMem[ADDR_W'(i)] = ADDR_W'($urandom);

      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [LEN_W-1:0] l;
         r = int'($urandom_range(0, 9));
         if (r == 0) l = '0;
         else if (r < 8) l = LEN_W'($urandom_range(1, 4));
         else l = LEN_W'($urandom_range(5, 40));
`ifdef PAGE_RECYCLE_CNT_EN
         pagePop = ($urandom_range(0, 3) == 0);
`endif
         applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom), l);
      end
`ifdef PAGE_RECYCLE_CNT_EN
      pagePop = 1'b0;
`endif
      drain();

      // Queue full: four long chains stalled behind an active walk, fifth held.
      t0 = cyc;
      applyStimulus(1'b1, 11'd100, 7'd100);
      for (int k = 1; k <= 4; k++) applyStimulus(1'b1, ADDR_W'(100 + k), 7'd100);
      checkOutput("full ready low", 32'(bus.rel_ready), 32'd0);
      while (cyc < t0 + 101) applyStimulus(1'b1, 11'd200, 7'd3);
      checkOutput("full ready at pop", 32'(bus.rel_ready), 32'd0);
      applyStimulus(1'b1, 11'd200, 7'd3);
      checkOutput("ready after pop", 32'(bus.rel_ready), 32'd1);
      applyStimulus(1'b1, 11'd200, 7'd3);
      drain();

      // Reset during page 3 of an 8-page chain.
      t0 = cyc;
      applyStimulus(1'b1, 11'd300, 7'd8);
      repeat (3) applyStimulus(1'b0, '0, '0);
      #2;
      checkOutput("page3 push_tail", 32'(bus.push_tail), 32'd1);
      checkOutput("page3 tail_addr", 32'(bus.tail_addr), pushAt.exists(t0 + 4) ? pushAt[t0 + 4] : -1);
      bus.rel_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkResetValues("midwalk");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      repeat (12) applyStimulus(1'b0, '0, '0);

`ifdef PAGE_RECYCLE_CNT_EN
      pagePop = 1'b1;
      repeat (3) applyStimulus(1'b0, '0, '0);
      pagePop = 1'b0;
      applyStimulus(1'b1, 11'd400, 7'd1);
      repeat (2) applyStimulus(1'b0, '0, '0);
      checkOutput("cnt 3 pops 1 push", 32'(freeCnt), 32'd2046);
      applyStimulus(1'b1, 11'd401, 7'd1);
      applyStimulus(1'b0, '0, '0);
      pagePop = 1'b1;
      applyStimulus(1'b0, '0, '0);
      pagePop = 1'b0;
      checkOutput("cnt push+pop", 32'(freeCnt), 32'd2046);
      applyStimulus(1'b1, 11'd402, 7'd2);
      applyStimulus(1'b1, 11'd403, 7'd1);
      drain();
      checkOutput("cnt saturate high", 32'(freeCnt), 32'd2048);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/page_chain_recycler.md
# page_chain_recycler

Returns released packet page chains to the free-page FIFO. It accepts (head page, page count) release requests into a small queue. It walks each chain through the external next-page link RAM and emits one push_tail/tail_addr pair per page into the free-page FIFO at one page per cycle. It sits between the packet dequeue logic (upstream) and the free-page FIFO push port (downstream).

## Interface
- ADDR_W, 11: page address width (2048 pages).
- LEN_W, 7: chain length field width; legal lengths are 1..2^LEN_W-1.
- QDEPTH, 4: release request queue depth (power of two, ≥2).

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rel_valid  in  1  release request valid.
- rel_ready  out  1  queue can accept a request; equals !queue_full.
- rel_head  in  ADDR_W  first page of the chain.
- rel_len  in  LEN_W  number of pages in the chain.
- link_rd_en  out  1  link RAM read strobe.
- link_rd_addr  out  ADDR_W  link RAM read address.
- link_rd_data  in  ADDR_W  next-page pointer, valid the cycle after link_rd_en.
- push_tail  out  1  push one page into the free-page FIFO.
- tail_addr  out  ADDR_W  page being pushed.
- busy  out  1  queue non-empty or walker active.
- err_zero_len  out  1  one-cycle pulse when a request with rel_len=0 is dropped.
- page_pop  in  1  mirror of the free-list pop strobe; only with PAGE_RECYCLE_CNT_EN.
- free_cnt  out  ADDR_W+1  free-list occupancy; only with PAGE_RECYCLE_CNT_EN.

## Operation
- Enqueue:
  - A request is accepted when rel_valid && rel_ready.
  - rel_len=0 is accepted but not stored, and err_zero_len pulses the next cycle.
  - There is no bypass: an accepted request becomes visible in the queue on the next cycle.
- Walker FSM has two states, IDLE and WALK. It holds registers first, head_r and rem (LEN_W).
- Load:
  - In IDLE, a non-empty queue pops its head entry. The FSM latches head_r and rem=len, sets first=1 and moves to WALK.
  - In WALK on the last page (rem==1), a non-empty queue pops its head entry and loads it the same way, so the FSM stays in WALK.
  - On the last page with an empty queue, the FSM returns to IDLE.
- Page selection in WALK: cur = first ? head_r : link_rd_data (combinational mux).
- Each WALK cycle:
  - Drives push_tail=1 and tail_addr=cur.
  - rem decrements; first clears.
  - If rem>1, drives link_rd_en=1 and link_rd_addr=cur. On the last page there is no link read.
- Link contents are not range-checked; the walker trusts the upstream chain.
- Outputs in IDLE: push_tail=0, link_rd_en=0, tail_addr=0, link_rd_addr=0.

## Timing
- Reset values: rel_ready=1, push_tail=0, tail_addr=0, link_rd_en=0, link_rd_addr=0, busy=0, err_zero_len=0, free_cnt=2048. The queue is emptied and the FSM goes to IDLE.
- Reset mid-walk: in-flight and queued chains are discarded, with no partial pushes after rst_n deasserts.
- Latency: a request accepted at cycle t is loaded at t+1. Its first push is at t+2 and pushes run through t+L+1.
- Throughput: 1 page/cycle. Chains queued back-to-back produce gapless pushes: the last page of A is at cycle u and the first page of B is at u+1.
- Queue full: rel_ready is low in that cycle, even if a pop occurs in the same cycle.
- Queue pointers wrap modulo QDEPTH; occupancy is tracked with a log2(QDEPTH)+1 bit count.
- busy is registered and is high from the cycle after acceptance through the last push cycle.

## Configuration
- PAGE_RECYCLE_CNT_EN defined:
  - page_pop and free_cnt exist.
  - free_cnt updates each cycle as follows: +1 on push_tail only, −1 on page_pop only, unchanged when both or neither.
  - free_cnt saturates at 0 and at 2048.
- Not defined: neither port exists and there is no counter logic.

## Test plan
- Single chain: head=5, len=3, link[5]=9, link[9]=2, accepted at t.
  - Pushes 5, 9, 2 at t+2..t+4.
  - link_rd_addr is 5 at t+2 and 9 at t+3; no read at t+4.
  - busy falls at t+5.
- Back-to-back chains: (head=10, len=2) then (head=20, len=1) accepted on consecutive cycles.
  - Pushes 10, link[10], 20 on three consecutive cycles with no gap.
- Queue full: 4 requests of len=100 stalled behind an active walk.
  - rel_ready=0 with the fifth request held.
  - rel_ready=1 the cycle after the queue pops.
- Zero length: rel_len=0 accepted.
  - err_zero_len pulses once.
  - No push occurs; queue occupancy is unchanged.
- Reset mid-walk: assert rst_n=0 during page 3 of a len=8 chain.
  - All outputs take their reset values immediately.
  - No push_tail occurs after release.
- PAGE_RECYCLE_CNT_EN:
  - From reset, 3 page_pop then 1 push gives free_cnt=2046.
  - Simultaneous page_pop and push_tail leave the count unchanged.
  - A push at 2048 holds the count at 2048.
